uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data port, alongside the data RAM. It consumes CPU stores (word address, write data, byte write-enables) and queues bytes in a FIFO. It serialises them as 8N1 frames on `tx`. Read data is registered with one-cycle latency, the same timing as the data RAM, so the CPU load path needs no change.

## Interface

Parameters:
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..64.
- `DIV_RESET`, 16'd103: reset value of BAUDDIV; bit period = BAUDDIV+1 clocks.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `sel` in 1: address decode hit for this peripheral; writes are ignored when low.
- `addr` in 2: word offset in the peripheral (0 TXDATA, 1 STATUS, 2 BAUDDIV, 3 reserved).
- `wen` in 4: per-byte write enables, lane 0 = bits [7:0].
- `wdata` in 32: store data.
- `rdata` out 32: registered read data.
- `tx` out 1: serial output, idle high, registered.

## Operation

- Write strobe: `sel` high and `wen` not zero, sampled at the rising edge.
- TXDATA (addr 0):
  - A write with `wen[0]` pushes `wdata[7:0]`. Other lanes are ignored.
  - A write without `wen[0]` has no effect.
  - A push when the FIFO is full is dropped and sets sticky `ovf`.
  - Reads return 0.
- STATUS (addr 1), read:
  - bit0 `full`.
  - bit1 `empty`.
  - bit2 `busy` (state is not IDLE).
  - bit3 `ovf`.
  - bits [15:8] FIFO level (0..FIFO_DEPTH).
  - All other bits 0.
- STATUS write: with `wen[0]` and `wdata[3]`=1, `ovf` is cleared. If overflow and clear happen in the same cycle, overflow wins.
- BAUDDIV (addr 2):
  - 16 bits, byte-lane writable via `wen[0]` and `wen[1]`.
  - Reads return the value zero-extended.
  - The divider is latched into the bit counter at each frame start. Writes during a frame take effect from the next frame.
- Reserved (addr 3): reads 0, writes are ignored.
- Read path:
  - `rdata` is updated every edge from `addr`, regardless of `sel`.
  - It returns the register value before any write on that same edge (read-before-write).
- FIFO:
  - Circular buffer with read/write pointers and an explicit level counter.
  - Push and pop in the same cycle: both happen and the level is unchanged. This includes the full case, because the pop frees a slot.
  - Pointers wrap modulo FIFO_DEPTH.
- TX FSM, with `bitcnt` (3b) and `divcnt` (16b):
  - IDLE: `tx`=1. If the FIFO is not empty, pop into the shift register, load `divcnt`=BAUDDIV, go to START.
  - START: `tx`=0 for BAUDDIV+1 clocks, then go to DATA with `bitcnt`=0.
  - DATA: `tx`=shift[0], LSB first. Each bit lasts BAUDDIV+1 clocks. After bit 7, go to STOP.
  - STOP: `tx`=1 for BAUDDIV+1 clocks. At the end, if the FIFO is not empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
  - BAUDDIV=0 is legal: one clock per bit.

## Timing

- Reset values:
  - `tx`=1, `rdata`=0.
  - State IDLE.
  - FIFO empty, pointers 0.
  - `ovf`=0, BAUDDIV=DIV_RESET.
- Reset takes priority over everything. Reset mid-frame aborts the frame: `tx`=1 from the edge after reset is sampled low, and the FIFO is flushed.
- Write/read latency:
  - A TXDATA write at edge N updates the level at N.
  - A STATUS read issued at edge N+1 shows the new level after edge N+1.
- Frame start: on an empty, idle unit, a push at edge N gives the pop at N+1 and `tx` falls at N+1.
- Frame length: 10·(BAUDDIV+1) clocks from the `tx` fall to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge right after the stop bit's last clock.
- `busy` is high from the pop edge through the last stop-bit clock.

## Test plan

- Reset: hold `resetn`=0 for 2 edges. Expect `tx`=1, STATUS read = 0x00000002, BAUDDIV read = 103.
- Single byte:
  - Set BAUDDIV=3, write 0x55 to TXDATA.
  - `tx` falls 1 edge later.
  - Sampled every 4 clocks, `tx` reads 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop).
  - Total frame 40 clocks, then `busy`=0.
- FIFO full and overflow:
  - BAUDDIV=100, write 10 bytes on consecutive cycles.
  - The first byte is popped immediately. FIFO level reaches 8 and `full`=1.
  - The 10th write is dropped: `ovf`=1, STATUS = 0x0000080D.
  - Writing STATUS with 0x8 clears `ovf`.
- Back-to-back frames: BAUDDIV=0, write 0xA5 then 0x3C. Expect 20 consecutive clocks of valid framing, with no idle-high cycle between the frames.
- Byte lanes:
  - TXDATA write with `wen`=4'b0010: level stays 0.
  - BAUDDIV write 0x00001234 with `wen`=4'b0001: readback = 0x0034.
- Reset mid-frame: assert `resetn`=0 during data bit 3 with 2 bytes queued. Expect `tx`=1 on the next edge, `empty`=1, and no further frame after release.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/BAUDDIV registers,
// TX FIFO and a serialiser, with registered read data matching data-RAM timing.
module uart_tx_mmio #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd103
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic [3:0]  wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          full;
  logic          empty;
  logic          wr_stb;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          ovf;
  logic          ovf_clr;
  logic [15:0]   bauddiv;
  logic [15:0]   framediv;
  logic [15:0]   divcnt;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;
  logic          bit_end;
  logic [31:0]   status;
  logic          unused_wdata;

  assign unused_wdata = ^wdata[31:16];

  assign wr_stb   = sel && (wen != '0);
  assign full     = (level == (AW+1)'(FIFO_DEPTH));
  assign empty    = (level == '0);
  assign bit_end  = (divcnt == '0);
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_end));
  assign push_req = wr_stb && (addr == 2'd0) && wen[0];
  // A push into a full FIFO still lands when the same edge pops a slot free.
  assign push     = push_req && (!full || pop);
  assign ovf_clr  = wr_stb && (addr == 2'd1) && wen[0] && wdata[3];

  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = (state != IDLE);
    status[3]     = ovf;
    status[15:8]  = 8'(level);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + (AW+1)'(1);
      end else if (pop && !push) begin
        level <= level - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ovf     <= 1'b0;
      bauddiv <= DIV_RESET;
      rdata   <= '0;
    end else begin
      if (push_req && !push) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
      if (wr_stb && (addr == 2'd2)) begin
        if (wen[0]) bauddiv[7:0]  <= wdata[7:0];
        if (wen[1]) bauddiv[15:8] <= wdata[15:8];
      end
      case (addr)
        2'd1:    rdata <= status;
        2'd2:    rdata <= {16'h0000, bauddiv};
        default: rdata <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      tx       <= 1'b1;
      divcnt   <= '0;
      framediv <= '0;
      bitcnt   <= '0;
      shift    <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            divcnt   <= bauddiv;
            framediv <= bauddiv;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            bitcnt <= '0;
            tx     <= shift[0];
            shift  <= shift >> 1;
            divcnt <= framediv;
            state  <= DATA;
          end else begin
            divcnt <= divcnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            divcnt <= framediv;
            if (bitcnt == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              tx     <= shift[0];
              shift  <= shift >> 1;
            end
          end else begin
            divcnt <= divcnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift    <= mem[rd_ptr];
              divcnt   <= bauddiv;
              framediv <= bauddiv;
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            divcnt <= divcnt - 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: register access, framing, FIFO
// overflow, back-to-back frames and reset abort, with a byte scoreboard.
module tb_uart_tx_mmio;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sel;
  logic [1:0]  addr;
  logic [3:0]  wen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        tx;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  uart_tx_mmio #(.FIFO_DEPTH(8), .DIV_RESET(16'd103)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sel    (sel),
    .addr   (addr),
    .wen    (wen),
    .wdata  (wdata),
    .rdata  (rdata),
    .tx     (tx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [3:0] we, input logic [31:0] d);
    sel   = 1'b1;
    addr  = a;
    wen   = we;
    wdata = d;
    tick();
    sel   = 1'b0;
    wen   = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    tick();
    d = rdata;
  endtask

  // Waits for a start bit, samples each bit at its first clock, scores the byte.
  task automatic collect_frame(input int div, input string tag, output int waited);
    int budget;
    logic [7:0] b;
    logic [7:0] exp;
    logic stopb;
    budget = 12 * (div + 1) + 20;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (tx !== 1'b0 && waited < budget);
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_timeout tx=%b required=0 after %0d cycles", tag, tx, waited);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      repeat (div + 1) tick();
      b[i] = tx;
    end
    repeat (div + 1) tick();
    stopb = tx;
    checks++;
    if (stopb !== 1'b1) begin
      failures++;
      $display("FAIL %s_stop got=%b required=1", tag, stopb);
    end
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL %s_unexpected_frame got=%02h required=no frame", tag, b);
    end else begin
      exp = sb.pop_front();
      if (b !== exp) begin
        failures++;
        $display("FAIL %s_byte got=%02h required=%02h", tag, b, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL reset_tx got=%b required=1", tx);
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got=%08h required=00000000", rdata);
    end
    resetn = 1'b1;
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_status got=%08h required=00000002", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'd103) begin
      failures++;
      $display("FAIL reset_bauddiv got=%08h required=%08h", d, 32'd103);
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    int w;
    wr(2'd2, 4'b0011, 32'd3);
    sb.push_back(8'h55);
    wr(2'd0, 4'b0001, 32'h0000_0055);
    collect_frame(3, "single", w);
    checks++;
    if (w !== 1) begin
      failures++;
      $display("FAIL single_fall_latency got=%0d required=1", w);
    end
    repeat (3) tick();
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0006) begin
      failures++;
      $display("FAIL single_busy_last_stop got=%08h required=00000006", d);
    end
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL single_idle_after_frame got=%08h required=00000002", d);
    end
  endtask

  task automatic test_overflow();
    int w;
    wr(2'd2, 4'b0011, 32'd100);
    for (int i = 0; i < 9; i++) sb.push_back(8'(8'h80 + i));
    fork
      begin
        logic [31:0] d;
        for (int i = 0; i < 10; i++) wr(2'd0, 4'b0001, 32'(8'h80 + i));
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0000_080D) begin
          failures++;
          $display("FAIL ovf_status got=%08h required=0000080D", d);
        end
        wr(2'd1, 4'b0001, 32'h0000_0008);
        rd(2'd1, d);
        checks++;
        if (d !== 32'h0000_0805) begin
          failures++;
          $display("FAIL ovf_clear got=%08h required=00000805", d);
        end
      end
      begin
        for (int f = 0; f < 9; f++) collect_frame(100, "ovf_frame", w);
      end
    join
    repeat (102) tick();
  endtask

  task automatic test_back_to_back();
    int w1;
    int w2;
    wr(2'd2, 4'b0011, 32'd0);
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    fork
      begin
        wr(2'd0, 4'b0001, 32'h0000_00A5);
        wr(2'd0, 4'b0001, 32'h0000_003C);
      end
      begin
        collect_frame(0, "b2b_first", w1);
        collect_frame(0, "b2b_second", w2);
      end
    join
    checks++;
    if (w2 !== 1) begin
      failures++;
      $display("FAIL b2b_gap got=%0d cycles to start required=1", w2);
    end
    repeat (3) tick();
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d;
    wr(2'd0, 4'b0010, 32'h0000_FFFF);
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL lanes_txdata_no_push got=%08h required=00000002", d);
    end
    wr(2'd2, 4'b0001, 32'h0000_1234);
    checks++;
    if (rdata !== 32'h0000_0000) begin
      failures++;
      $display("FAIL lanes_read_before_write got=%08h required=00000000", rdata);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h0000_0034) begin
      failures++;
      $display("FAIL lanes_bauddiv got=%08h required=00000034", d);
    end
    wr(2'd3, 4'b1111, 32'hFFFF_FFFF);
    rd(2'd3, d);
    checks++;
    if (d !== 32'h0) begin
      failures++;
      $display("FAIL lanes_reserved_read got=%08h required=00000000", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'h0000_0034) begin
      failures++;
      $display("FAIL lanes_reserved_write got=%08h required=00000034", d);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int highs;
    wr(2'd2, 4'b0011, 32'd3);
    wr(2'd0, 4'b0001, 32'h0000_0011);
    wr(2'd0, 4'b0001, 32'h0000_0022);
    wr(2'd0, 4'b0001, 32'h0000_0033);
    repeat (16) tick();
    checks++;
    if (tx !== 1'b0) begin
      failures++;
      $display("FAIL midframe_bit3 got=%b required=0", tx);
    end
    resetn = 1'b0;
    tick();
    checks++;
    if (tx !== 1'b1) begin
      failures++;
      $display("FAIL midframe_abort_tx got=%b required=1", tx);
    end
    tick();
    resetn = 1'b1;
    rd(2'd1, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL midframe_flushed got=%08h required=00000002", d);
    end
    rd(2'd2, d);
    checks++;
    if (d !== 32'd103) begin
      failures++;
      $display("FAIL midframe_bauddiv got=%08h required=%08h", d, 32'd103);
    end
    highs = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx === 1'b1) highs++;
    end
    checks++;
    if (highs !== 60) begin
      failures++;
      $display("FAIL midframe_no_frame high_cycles=%0d required=60", highs);
    end
  endtask

  initial begin
    resetn = 1'b0;
    sel    = 1'b0;
    addr   = 2'd0;
    wen    = '0;
    wdata  = '0;
    test_reset();
    test_single();
    test_overflow();
    test_back_to_back();
    test_byte_lanes();
    test_reset_midframe();
    checks++;
    if (sb.size() !== 0) begin
      failures++;
      $display("FAIL scoreboard_drain remaining=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time=%0t required=finish before limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
